// File: rtl/transpose_buffer.sv
// Ping-pong N x N block buffer between the row-DCT and column-DCT stages.
// Each block leaves as its columns (transpose) or unchanged rows (bypass).
module transpose_buffer #(
    parameter int N = 8,
    parameter int W = 8
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           STBi,
    input  logic [N*W-1:0] DATi,
    input  logic           TRN,
    output logic           ACKi,
    output logic           STBo,
    output logic [N*W-1:0] DATo,
    output logic           LASTo,
    input  logic           ACKo
);

    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW-1:0] ROW_LAST = AW'(N - 1);

    // Register storage: a transposed read needs one sample from every row at once.
    logic [N*W-1:0] mem [2][N];

    logic [1:0]    full_reg, full_next;
    logic [1:0]    mode_reg, mode_next;
    logic          wr_bank_reg, rd_bank_reg;
    logic [AW-1:0] wr_row_reg, rd_row_reg;
    logic          wr_fire, rd_fire, wr_last, rd_last;
    logic [N*W-1:0] tr_row, by_row;

    assign ACKi    = ~full_reg[wr_bank_reg];
    assign STBo    = full_reg[rd_bank_reg];
    assign wr_fire = STBi & ACKi;
    assign rd_fire = STBo & ACKo;
    assign wr_last = wr_fire & (wr_row_reg == ROW_LAST);
    assign rd_last = rd_fire & (rd_row_reg == ROW_LAST);

    // Set and clear always address different banks, so both apply together.
    always_comb begin
        full_next = full_reg;
        mode_next = mode_reg;
        for (int b = 0; b < 2; b++) begin
            if (wr_last && (wr_bank_reg == 1'(b)))
                full_next[b] = 1'b1;
            if (rd_last && (rd_bank_reg == 1'(b)))
                full_next[b] = 1'b0;
            if (wr_fire && (wr_row_reg == '0) && (wr_bank_reg == 1'(b)))
                mode_next[b] = TRN;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            full_reg    <= '0;
            mode_reg    <= '0;
            wr_bank_reg <= 1'b0;
            rd_bank_reg <= 1'b0;
            wr_row_reg  <= '0;
            rd_row_reg  <= '0;
        end else begin
            full_reg <= full_next;
            mode_reg <= mode_next;
            if (wr_fire) begin
                wr_row_reg <= wr_row_reg + 1'b1;
                if (wr_last)
                    wr_bank_reg <= ~wr_bank_reg;
            end
            if (rd_fire) begin
                rd_row_reg <= rd_row_reg + 1'b1;
                if (rd_last)
                    rd_bank_reg <= ~rd_bank_reg;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_fire)
            mem[wr_bank_reg][wr_row_reg] <= DATi;
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_col
            assign tr_row[gi*W +: W] = mem[rd_bank_reg][gi][rd_row_reg*W +: W];
        end
    endgenerate

    assign by_row = mem[rd_bank_reg][rd_row_reg];
    assign DATo   = STBo ? (mode_reg[rd_bank_reg] ? tr_row : by_row) : '0;
    assign LASTo  = STBo & (rd_row_reg == ROW_LAST);

endmodule

// File: tb/tb_transpose_buffer.sv
// Directed and randomised-stall bench for transpose_buffer with N=8, W=8.
// Expected rows come from hand constants and a block-level reference queue.
module tb_transpose_buffer;

    localparam int N = 8;
    localparam int W = 8;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        STBi = 1'b0;
    logic [63:0] DATi = '0;
    logic        TRN = 1'b0;
    logic        ACKi;
    logic        STBo;
    logic [63:0] DATo;
    logic        LASTo;
    logic        ACKo = 1'b0;

    always #5 CLK = ~CLK;

    transpose_buffer #(.N(N), .W(W)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .STBi (STBi),
        .DATi (DATi),
        .TRN  (TRN),
        .ACKi (ACKi),
        .STBo (STBo),
        .DATo (DATo),
        .LASTo(LASTo),
        .ACKo (ACKo)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] exp_q[$];
    logic [63:0] blk [8];
    logic        in_mode;
    int          in_row = 0;
    int          out_row = 0;
    int          out_count = 0;

    logic        s_acki, s_stbo, s_lasto, s_in, s_out;
    logic [63:0] s_dato;
    logic        hold_prev = 1'b0;
    logic        hold_last;
    logic [63:0] hold_dat;

    int   nr, acc, oc0, iter;
    logic sv;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rowval(input int r);
        logic [63:0] v;
        for (int c = 0; c < 8; c++)
            v[c*8 +: 8] = 8'(8*r + c);
        return v;
    endfunction

    // One clock cycle: drive, sample at negedge, score, advance to just past the edge.
    task automatic step(input logic stbi, input logic [63:0] dati, input logic trn, input logic acko);
        logic [63:0] v;
        STBi = stbi; DATi = dati; TRN = trn; ACKo = acko;
        @(negedge CLK);
        s_acki = ACKi; s_stbo = STBo; s_lasto = LASTo; s_dato = DATo;
        s_in  = STBi & ACKi;
        s_out = STBo & ACKo;
        if (!s_stbo) begin
            check("dat_idle", s_dato, 64'd0);
            check("last_idle", 64'(s_lasto), 64'd0);
        end
        if (hold_prev) begin
            check("hold_stb", 64'(s_stbo), 64'd1);
            check("hold_dat", s_dato, hold_dat);
            check("hold_last", 64'(s_lasto), 64'(hold_last));
        end
        hold_prev = s_stbo & ~acko;
        hold_dat  = s_dato;
        hold_last = s_lasto;
        if (s_out) begin
            if (exp_q.size() == 0)
                check("spurious_out", 64'd1, 64'd0);
            else begin
                check("dato", s_dato, exp_q.pop_front());
                check("lasto", 64'(s_lasto), 64'(out_row == 7));
            end
            out_row = (out_row + 1) % 8;
            out_count++;
        end
        if (s_in) begin
            if (in_row == 0)
                in_mode = trn;
            blk[in_row] = dati;
            if (in_row == 7) begin
                for (int r = 0; r < 8; r++) begin
                    if (in_mode) begin
                        for (int k = 0; k < 8; k++)
                            v[k*8 +: 8] = blk[k][r*8 +: 8];
                    end else
                        v = blk[r];
                    exp_q.push_back(v);
                end
            end
            in_row = (in_row + 1) % 8;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b0; STBi = 1'b0; ACKo = 1'b0; TRN = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        exp_q.delete();
        in_row = 0;
        out_row = 0;
        hold_prev = 1'b0;
        @(negedge CLK);
        check("rst_stbo", 64'(STBo), 64'd0);
        check("rst_acki", 64'(ACKi), 64'd1);
        check("rst_dato", DATo, 64'd0);
        check("rst_lasto", 64'(LASTo), 64'd0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        do_reset();

        // Single transposed block
        for (int r = 0; r < 8; r++) begin
            step(1'b1, rowval(r), 1'b1, 1'b1);
            check("t1_acki", 64'(s_acki), 64'd1);
        end
        check("t1_stbo_early", 64'(s_stbo), 64'd0);
        for (int r = 0; r < 8; r++) begin
            step(1'b0, 64'd0, 1'b0, 1'b1);
            check("t1_stbo", 64'(s_stbo), 64'd1);
            check("t1_last", 64'(s_lasto), 64'(r == 7));
            if (r == 0) check("t1_row0", s_dato, 64'h3830282018100800);
            if (r == 7) check("t1_row7", s_dato, 64'h3F372F271F170F07);
        end
        step(1'b0, 64'd0, 1'b0, 1'b1);
        check("t1_stbo_after", 64'(s_stbo), 64'd0);

        // Bypass block, TRN toggling on non-first rows
        for (int r = 0; r < 8; r++)
            step(1'b1, rowval(r), 1'(r % 2), 1'b1);
        for (int r = 0; r < 8; r++) begin
            step(1'b0, 64'd0, 1'b0, 1'b1);
            check("t2_row", s_dato, rowval(r));
        end
        step(1'b0, 64'd0, 1'b0, 1'b1);
        check("t2_empty", 64'(exp_q.size()), 64'd0);

        // Three back-to-back blocks at full rate
        oc0 = out_count;
        for (int cyc = 0; cyc < 32; cyc++) begin
            step(1'(cyc < 24), rowval(cyc), 1'((cyc / 8) != 1), 1'b1);
            if (cyc < 24) check("t3_acki", 64'(s_acki), 64'd1);
            if (cyc >= 8) check("t3_stbo", 64'(s_stbo), 64'd1);
        end
        check("t3_rows", 64'(out_count - oc0), 64'd24);

        // Backpressure: both banks fill, then reopen after 8th transfer
        nr = 0;
        oc0 = out_count;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, rowval(nr), 1'((nr / 8) % 2 == 0), 1'b0);
            if (s_in) nr++;
        end
        check("t4_accepted", 64'(nr), 64'd16);
        check("t4_acki_low", 64'(s_acki), 64'd0);
        for (int p = 0; p < 7; p++) begin
            step(1'b1, rowval(nr), 1'b1, 1'b1);
            check("t4_acki_hold", 64'(s_acki), 64'd0);
            check("t4_xfer", 64'(s_out), 64'd1);
        end
        step(1'b1, rowval(nr), 1'b1, 1'b1);
        check("t4_acki_8th", 64'(s_acki), 64'd0);
        step(1'b1, rowval(nr), 1'b1, 1'b1);
        check("t4_acki_reopen", 64'(s_acki), 64'd1);
        if (s_in) nr++;
        iter = 0;
        while (!(nr >= 24 && exp_q.size() == 0) && iter < 200) begin
            step(1'(nr < 24), rowval(nr), 1'((nr / 8) % 2 == 0), 1'b1);
            if (s_in) nr++;
            iter++;
        end
        check("t4_done", 64'(iter < 200), 64'd1);
        check("t4_rows", 64'(out_count - oc0), 64'd24);

        // Random stalls on both sides over 10 blocks
        acc = 0;
        oc0 = out_count;
        iter = 0;
        while ((acc < 80 || out_count - oc0 < 80) && iter < 5000) begin
            sv = (acc < 80) && ($urandom_range(0, 1) == 1);
            step(sv, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (s_in) acc++;
            iter++;
        end
        check("t5_timeout", 64'(iter < 5000), 64'd1);
        check("t5_rows", 64'(out_count - oc0), 64'd80);

        // Reset while block 1 drains and block 2 is partial
        for (int r = 0; r < 8; r++)
            step(1'b1, rowval(r), 1'b1, 1'b0);
        for (int r = 0; r < 5; r++) begin
            step(1'b1, rowval(8 + r), 1'b0, 1'b1);
            check("t6_in", 64'(s_in), 64'd1);
        end
        do_reset();
        for (int r = 0; r < 8; r++)
            step(1'b1, rowval(r), 1'b1, 1'b1);
        for (int r = 0; r < 8; r++) begin
            step(1'b0, 64'd0, 1'b0, 1'b1);
            check("t6_stbo", 64'(s_stbo), 64'd1);
            if (r == 0) check("t6_row0", s_dato, 64'h3830282018100800);
            if (r == 7) check("t6_row7", s_dato, 64'h3F372F271F170F07);
        end
        step(1'b0, 64'd0, 1'b0, 1'b1);
        check("t6_empty", 64'(s_stbo), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
